video_frame_source: RTL and testbench

//   Transmit end of the pixel-stream interface consumed by the filter stages.
//   - On a start request, reads one frame from a synchronous frame RAM in raster order (1-cycle read latency).
//   - Emits the pixels as pixel_out/pixel_valid/line_end/frame_end, inserting horizontal and vertical blanking.
//   - Sits between the frame store and the first filter stage.

---
 rtl/video_frame_source.sv | 177 +++++++++++++++++
 tb/tb_video_frame_source.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/video_frame_source.sv
// Reads one frame from a synchronous RAM in raster order and streams it with H/V blanking.
// Optional build macro VFS_TEST_PATTERN_EN replaces RAM data with an (x+y) ramp and keeps RAM idle.
module video_frame_source #(
   parameter int IMG_WIDTH  = 1920,
   parameter int IMG_HEIGHT = 1080,
   parameter int DATA_WIDTH = 8,
   parameter int H_BLANK    = 16,
   parameter int V_BLANK    = 64,
   parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic                  pixel_valid,
   output logic                  line_end,
   output logic                  frame_end
);

   localparam int XW   = $clog2(IMG_WIDTH);
   localparam int YW   = $clog2(IMG_HEIGHT);
   localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
   localparam int BW   = $clog2(BMAX);
   localparam logic [XW-1:0]         X_LAST  = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0]         Y_LAST  = YW'(IMG_HEIGHT - 1);
   localparam logic [ADDR_WIDTH-1:0] A_LAST  = ADDR_WIDTH'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [BW-1:0]         HB_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
   localparam logic [BW-1:0]         VB_LAST = BW'(V_BLANK - 1);

   if (V_BLANK < 2) begin : g_vblank_chk
      $error("video_frame_source: V_BLANK must be >= 2");
   end
   if (IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_size_chk
      $error("video_frame_source: IMG_WIDTH and IMG_HEIGHT must be >= 2");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

   state_t                  state_q, state_d;
   logic [XW-1:0]           x_q, x_d;
   logic [YW-1:0]           y_q, y_d;
   logic [BW-1:0]           bcnt_q, bcnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    done_q, done_d;
   logic                    busy_q, rd_en_q;
   logic                    s1_vld_q, s1_le_q, s1_fe_q;
   logic                    vld_q, le_q, fe_q;
   logic [DATA_WIDTH-1:0]   pix_q;
   logic                    act, last_x, last_y;

   assign act    = (state_q == S_ACTIVE);
   assign last_x = (x_q == X_LAST);
   assign last_y = (y_q == Y_LAST);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      bcnt_d  = bcnt_q;
      done_d  = 1'b0;
      addr_d  = addr_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_ACTIVE;
               x_d     = '0;
               y_d     = '0;
            end
         end
         S_ACTIVE: begin
            addr_d = (addr_q == A_LAST) ? '0 : addr_q + 1'b1;
            if (last_x) begin
               x_d    = '0;
               bcnt_d = '0;
               if (last_y) begin
                  y_d     = '0;
                  state_d = S_VBLANK;
               end else begin
                  y_d     = y_q + 1'b1;
                  state_d = (H_BLANK == 0) ? S_ACTIVE : S_HBLANK;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         S_HBLANK: begin
            if (bcnt_q == HB_LAST) state_d = S_ACTIVE;
            else                   bcnt_d  = bcnt_q + 1'b1;
         end
         S_VBLANK: begin
            if (bcnt_q == VB_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         bcnt_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         rd_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         bcnt_q  <= bcnt_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         busy_q  <= (state_d != S_IDLE);
`ifdef VFS_TEST_PATTERN_EN
         rd_en_q <= 1'b0;
`else
         rd_en_q <= (state_d == S_ACTIVE);
`endif
      end
   end

   // Two-stage pipe: stage 1 lines up with the RAM read, stage 2 captures its data.
`ifdef VFS_TEST_PATTERN_EN
   logic [DATA_WIDTH-1:0] s1_pix_q;
   logic                  unused_rd_data;
   assign unused_rd_data = ^mem_rd_data;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_le_q  <= 1'b0;
         s1_fe_q  <= 1'b0;
         vld_q    <= 1'b0;
         le_q     <= 1'b0;
         fe_q     <= 1'b0;
         pix_q    <= '0;
`ifdef VFS_TEST_PATTERN_EN
         s1_pix_q <= '0;
`endif
      end else begin
         s1_vld_q <= act;
         s1_le_q  <= act & last_x;
         s1_fe_q  <= act & last_x & last_y;
         vld_q    <= s1_vld_q;
         le_q     <= s1_le_q;
         fe_q     <= s1_fe_q;
`ifdef VFS_TEST_PATTERN_EN
         s1_pix_q <= DATA_WIDTH'(x_q) + DATA_WIDTH'(y_q);
         if (s1_vld_q) pix_q <= s1_pix_q;
`else
         if (s1_vld_q) pix_q <= mem_rd_data;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign mem_rd_en   = rd_en_q;
   assign mem_rd_addr = addr_q;
   assign pixel_out   = pix_q;
   assign pixel_valid = vld_q;
   assign line_end    = le_q;
   assign frame_end   = fe_q;

endmodule

// File: tb/tb_video_frame_source.sv
// Bench for video_frame_source: random start/reset stimulus, frame-level reference model,
// pixel scoreboard popped by a monitor, plus per-cycle timing checks derived from frame geometry.
`timescale 1ns/1ps
module tb_video_frame_source;
   localparam int W  = 4;
   localparam int H  = 3;
   localparam int DW = 8;
   localparam int VB = 3;
`ifdef VFS_TEST_PATTERN_EN
   localparam int HB  = 0;
   localparam bit PAT = 1'b1;
`else
   localparam int HB  = 2;
   localparam bit PAT = 1'b0;
`endif
   localparam int AW       = $clog2(W * H);
   localparam int P        = W + HB;
   localparam int DONE_OFF = 1 + H * W + (H - 1) * HB + VB;

   logic          clk, rst_n, start;
   logic          busy, done, mem_rd_en, pixel_valid, line_end, frame_end;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data, pixel_out;

   video_frame_source #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .H_BLANK(HB), .V_BLANK(VB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .pixel_out(pixel_out), .pixel_valid(pixel_valid), .line_end(line_end),
      .frame_end(frame_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame RAM holding RAM[i] = i + 16.
   initial mem_rd_data = '0;
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= DW'(mem_rd_addr) + 8'd16;

   typedef struct {
      logic [DW-1:0] dat;
      logic          le;
      logic          fe;
   } pix_t;

   pix_t          exp_q[$];
   int            cyc = 0;
   int            c0 = 0;
   bit            have_frame = 1'b0;
   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] hold_exp = '0;

   function automatic bit in_read(int k);
      return (k >= 0) && ((k / P) < H) && ((k % P) < W);
   endfunction

   function automatic int raster_idx(int k);
      return (k / P) * W + (k % P);
   endfunction

   task automatic chk(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   // Model: accept a frame when idle (the done cycle counts as idle) and queue its pixels.
   always @(posedge clk) begin
      pix_t p;
      if (!rst_n) begin
         have_frame = 1'b0;
         exp_q.delete();
      end else if (start && (!have_frame || cyc >= c0 + DONE_OFF)) begin
         have_frame = 1'b1;
         c0 = cyc;
         for (int i = 0; i < W * H; i++) begin
            p.dat = PAT ? DW'((i / W) + (i % W)) : DW'(i + 16);
            p.le  = ((i % W) == W - 1);
            p.fe  = (i == W * H - 1);
            exp_q.push_back(p);
         end
      end
      cyc++;
   end

   // Monitor and cycle-level checker.
   always @(negedge clk) begin
      int   k;
      bit   rd_e, v_e, b_e, d_e;
      pix_t p;
      if (!rst_n) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_rd_en", mem_rd_en, 0);
         chk("rst_addr", int'(mem_rd_addr), 0);
         chk("rst_valid", pixel_valid, 0);
         chk("rst_pixel", int'(pixel_out), 0);
         chk("rst_line_end", line_end, 0);
         chk("rst_frame_end", frame_end, 0);
         hold_exp = '0;
      end else begin
         k    = cyc - c0 - 1;
         rd_e = have_frame && in_read(k) && !PAT;
         v_e  = have_frame && in_read(k - 2);
         b_e  = have_frame && (cyc > c0) && (cyc < c0 + DONE_OFF);
         d_e  = have_frame && (cyc == c0 + DONE_OFF);
         chk("busy", busy, int'(b_e));
         chk("done", done, int'(d_e));
         chk("rd_en", mem_rd_en, int'(rd_e));
         chk("pixel_valid", pixel_valid, int'(v_e));
         if (rd_e) chk("rd_addr", int'(mem_rd_addr), raster_idx(k));
         if (pixel_valid) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_pixel at cycle %0d: got %0d, want none", cyc, pixel_out);
            end else begin
               p = exp_q.pop_front();
               chk("pixel_out", int'(pixel_out), int'(p.dat));
               chk("line_end", line_end, int'(p.le));
               chk("frame_end", frame_end, int'(p.fe));
               hold_exp = p.dat;
            end
         end else begin
            chk("idle_line_end", line_end, 0);
            chk("idle_frame_end", frame_end, 0);
            chk("pixel_hold", int'(pixel_out), int'(hold_exp));
         end
      end
   end

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      step(3);
      rst_n = 1'b1;

      // Single frame, with a stray start while busy at relative cycle 8.
      start = 1'b1; step(1);
      start = 1'b0; step(7);
      start = 1'b1; step(1);
      start = 1'b0; step(DONE_OFF + 8);

      // Start held high: frames run back to back.
      start = 1'b1; step(2 * DONE_OFF + 5);
      start = 1'b0; step(DONE_OFF + 10);

      // Reset in the middle of a frame, then a fresh frame.
      start = 1'b1; step(1);
      start = 1'b0; step(9);
      rst_n = 1'b0; step(2);
      rst_n = 1'b1; step(3);
      start = 1'b1; step(1);
      start = 1'b0; step(DONE_OFF + 5);

      // Random start pulses of random length, some landing while busy.
      repeat (8) begin
         step($urandom_range(0, 25));
         start = 1'b1; step($urandom_range(1, 3));
         start = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            step($urandom_range(1, 15));
            start = 1'b1; step(1);
            start = 1'b0;
         end
      end

      // Random start toggling with one reset pulse.
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 7) == 0);
         if (i == 200) rst_n = 1'b0;
         if (i == 202) rst_n = 1'b1;
         step(1);
      end
      start = 1'b0;
      step(DONE_OFF + 10);

      chk("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
